// File: rtl/ifetch_prefetch_queue_pkg.sv
// ifetch_prefetch_queue_pkg: shared fetch state, entry type and reset PC.
package ifetch_prefetch_queue_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_prefetch_queue_fifo.sv
// fetch_fifo: small FIFO of fetch entries; flush beats enq/deq, head holds last value when empty.
module fetch_fifo import ifetch_prefetch_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  T                         din,
  input  logic                     deq,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  T last;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_enq, do_deq, empty;
  assign empty = (count == '0);
  assign do_enq = enq & ~flush & (count != CW'(DEPTH));
  assign do_deq = deq & ~flush & ~empty;
  assign head = empty ? last : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_enq) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      last   <= head;
      rd_ptr <= flush ? '0 : rd_ptr + AW'(do_deq);
      wr_ptr <= flush ? '0 : wr_ptr + AW'(do_enq);
      count  <= flush ? '0 : count + CW'(do_enq) - CW'(do_deq);
    end
endmodule

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: one-outstanding sequential fetcher feeding a {pc, ir} FIFO to decode.
module ifetch_prefetch_queue import ifetch_prefetch_queue_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_read,
  output logic [31:0]            imem_address,
  input  logic                   imem_resp,
  input  logic [31:0]            imem_rdata,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_ir,
  input  logic                   if_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state;
  fetch_entry_t din, head;
  logic [31:0] fetch_pc, target;
  logic enq, deq;
  assign target = redirect_pc & ~32'h3;
  assign enq = (state == REQ) & imem_resp & ~redirect;
  assign deq = if_valid & if_ready;
  assign din = '{pc: fetch_pc, ir: imem_rdata};
  assign imem_read = (state != IDLE);
  assign if_valid = (count != '0);
  assign if_pc = head.pc;
  assign if_ir = head.ir;
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk), .rst(rst), .enq(enq), .din(din), .deq(deq),
    .flush(redirect), .head(head), .count(count)
  );
  // a redirect while a request is in flight must still wait out that response (DROP)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      imem_address <= '0;
    end else begin
      fetch_pc <= redirect ? target : enq ? fetch_pc + 32'd4 : fetch_pc;
      if (state == IDLE && !redirect && count < CW'(DEPTH)) begin
        state        <= REQ;
        imem_address <= fetch_pc;
      end else if (state == REQ && redirect && !imem_resp)
        state <= DROP;
      else if (state != IDLE && imem_resp)
        state <= IDLE;
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: scoreboard + vector-table bench for the prefetch queue.
module tb_ifetch_prefetch_queue;
  import ifetch_prefetch_queue_pkg::*;
  logic clk = 0, rst = 1;
  logic imem_read, imem_resp = 0, if_valid, if_ready = 0, redirect = 0;
  logic [31:0] imem_address, imem_rdata = 0, if_pc, if_ir, redirect_pc = 0;
  logic [2:0] count;
  int checks = 0, fails = 0, pops = 0, lat = 1, wcnt = 0;
  logic [31:0] hold = 0, dmask = 0;
  bit dropping = 0;
  fetch_entry_t sb[$];
  logic [31:0] issued[$];
  typedef struct { logic [31:0] tgt; logic [31:0] a0; logic [31:0] a1; int lat; } rd_vec_t;
  rd_vec_t vt[4];

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h60)) dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_ir(if_ir), .if_ready(if_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic mem_model();
    imem_resp = 0;
    if (rst || !imem_read) wcnt = 0;
    else begin
      if (wcnt == 0) begin
        issued.push_back(imem_address);
        hold = imem_address;
      end else chk("addr_stable", imem_address, hold);
      wcnt++;
      if (wcnt >= lat) begin
        imem_resp = 1;
        imem_rdata = imem_address ^ dmask;
        wcnt = 0;
        if (dropping) dropping = 0;
        else sb.push_back('{pc: imem_address, ir: imem_rdata});
      end
    end
  endtask

  task automatic cyc();
    fetch_entry_t e;
    if (if_valid && if_ready && !redirect && !rst) begin
      if (sb.size() == 0) chk("pop_unexpected", if_pc, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk("pop_pc", if_pc, e.pc);
        chk("pop_ir", if_ir, e.ir);
        pops++;
      end
    end
    @(posedge clk); #1;
    redirect = 0;
    chk("count", 32'(count), 32'(sb.size()));
    mem_model();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1;
    redirect_pc = pc;
    if (imem_read && !imem_resp) dropping = 1;
    sb.delete();
    issued.delete();
  endtask

  task automatic wait_issue(input string name, input logic [31:0] exp, input int budget);
    int n = 0;
    while (issued.size() == 0 && n < budget) begin
      cyc();
      n++;
    end
    if (issued.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s timeout actual=none expected=%h", name, exp);
    end else chk(name, issued.pop_front(), exp);
  endtask

  task automatic do_reset();
    rst = 1;
    imem_resp = 0;
    redirect = 0;
    dropping = 0;
    wcnt = 0;
    sb.delete();
    issued.delete();
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    int p0, n;
    vt[0] = '{32'h0000_0403, 32'h0000_0400, 32'h0000_0404, 1};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 2};
    vt[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004, 3};
    vt[3] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008, 1};
    #1;
    chk("rst_read", imem_read, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_ir", if_ir, 0);
    chk("rst_count", 32'(count), 0);
    // in-order streaming, data equals address
    do_reset();
    if_ready = 1;
    lat = 1;
    wait_issue("seq0", 32'h60, 10);
    wait_issue("seq1", 32'h64, 10);
    wait_issue("seq2", 32'h68, 10);
    repeat (4) cyc();
    chk("seq_pops", 32'(pops >= 3), 1);
    // decode stalled: queue fills to DEPTH and fetch stops
    dmask = 32'hA5A5_0000;
    do_reset();
    if_ready = 0;
    repeat (20) cyc();
    chk("stall_nreq", 32'(issued.size()), 4);
    for (int i = 0; i < 4 && issued.size() > 0; i++) chk("stall_addr", issued.pop_front(), 32'h60 + 32'(4 * i));
    chk("stall_count", 32'(count), 4);
    chk("stall_read", imem_read, 0);
    if_ready = 1;
    p0 = pops;
    wait_issue("resume", 32'h70, 10);
    chk("resume_pop", 32'(pops > p0), 1);
    // redirect during a slow request: old address held, response dropped
    do_reset();
    lat = 5;
    wait_issue("slow0", 32'h60, 20);
    wait_issue("slow1", 32'h64, 20);
    cyc();
    do_redirect(32'h200);
    cyc();
    chk("drop_read", imem_read, 1);
    chk("drop_addr", imem_address, 32'h64);
    wait_issue("redir", 32'h200, 20);
    p0 = pops;
    repeat (15) cyc();
    chk("redir_pop", 32'(pops > p0), 1);
    // redirect coinciding with a response
    do_reset();
    lat = 3;
    if_ready = 0;
    wait_issue("co0", 32'h60, 20);
    wait_issue("co1", 32'h64, 20);
    n = 0;
    while (!imem_resp && n < 20) begin cyc(); n++; end
    chk("co_resp_seen", imem_resp, 1);
    do_redirect(32'h403);
    cyc();
    chk("co_count", 32'(count), 0);
    chk("co_valid", if_valid, 0);
    wait_issue("co_next", 32'h400, 10);
    // redirect together with a pop from a 3-entry queue
    do_reset();
    lat = 1;
    n = 0;
    while (count != 3 && n < 50) begin cyc(); n++; end
    chk("three_entries", 32'(count), 3);
    if_ready = 1;
    do_redirect(32'h800);
    cyc();
    chk("rp_count", 32'(count), 0);
    chk("rp_valid", if_valid, 0);
    // two redirects while dropping: latest wins
    do_reset();
    lat = 8;
    wait_issue("dd0", 32'h60, 20);
    cyc();
    do_redirect(32'h300);
    cyc();
    cyc();
    do_redirect(32'h500);
    cyc();
    wait_issue("dd_next", 32'h500, 20);
    // vector table: redirect target alignment and sequential wrap
    do_reset();
    if_ready = 1;
    for (int i = 0; i < 4; i++) begin
      lat = vt[i].lat;
      do_redirect(vt[i].tgt);
      cyc();
      wait_issue("vec_a0", vt[i].a0, 30);
      wait_issue("vec_a1", vt[i].a1, 30);
    end
    // async reset mid-request, then a stray response in IDLE
    do_reset();
    lat = 10;
    wait_issue("ar0", 32'h60, 20);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("ar_read", imem_read, 0);
    chk("ar_count", 32'(count), 0);
    imem_resp = 0;
    dropping = 0;
    wcnt = 0;
    sb.delete();
    issued.delete();
    cyc();
    rst = 0;
    lat = 2;
    imem_resp = 1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("stray_count", 32'(count), 0);
    imem_resp = 0;
    wait_issue("ar_restart", 32'h60, 10);
    repeat (4) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
